// File: rtl/pci_target_pkg.sv
// pci_target_pkg: bus commands, target FSM encoding and helpers
// shared by pci_simple_target and pci_target_regfile.
package pci_target_pkg;

  localparam logic [3:0] CMD_MEM_RD = 4'b0110;
  localparam logic [3:0] CMD_MEM_WR = 4'b0111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SKIP  = 3'd1,
    ST_RD_TA = 3'd2,
    ST_XFER  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_TURN  = 3'd5
  } state_e;

  function automatic logic cmd_supported(
    input logic [3:0] cmd
  );
    return (cmd == CMD_MEM_RD) ||
           (cmd == CMD_MEM_WR);
  endfunction

endpackage

// File: rtl/pci_target_regfile.sv
// pci_target_regfile: NUM_WORDS x 32 register file, one write
// port, one combinational read port, async clear on rst_i.
// Ports: clk_i, rst_i, we_i/waddr_i/wdata_i, raddr_i -> rdata_o.
module pci_target_regfile
  import pci_target_pkg::*;
#(
  parameter int unsigned NUM_WORDS = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         we_i,
  input  logic [$clog2(NUM_WORDS)-1:0] waddr_i,
  input  logic [31:0]                  wdata_i,
  input  logic [$clog2(NUM_WORDS)-1:0] raddr_i,
  output logic [31:0]                  rdata_o
);

  logic [31:0] mem_q [NUM_WORDS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/pci_simple_target.sv
// pci_simple_target: PCI-style memory target claiming a window of
// NUM_WORDS registers at BASE_ADDR; answers read/write bursts.
// Ports: clk, rst (async, high), FRAME/IRDY (low-active in),
// AD_IN, CBE in; AD_OUT, AD_OE, DEVSEL, TRDY (registered) out.
// Option: define TARGET_WAIT_EN for WAIT_CYCLES TRDY wait states.
module pci_simple_target
  import pci_target_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned NUM_WORDS   = 8,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        FRAME,
  input  logic        IRDY,
  input  logic [31:0] AD_IN,
  input  logic [3:0]  CBE,
  output logic [31:0] AD_OUT,
  output logic        AD_OE,
  output logic        DEVSEL,
  output logic        TRDY
);

  localparam int unsigned IW = $clog2(NUM_WORDS);
  localparam logic [29:0] BASE_W = BASE_ADDR[31:2];
  localparam logic [29:0] END_W  = BASE_W + 30'(NUM_WORDS);

  if (NUM_WORDS < 2 || NUM_WORDS > 256 ||
      (NUM_WORDS & (NUM_WORDS - 1)) != 0) begin : g_bad_words
    $error("NUM_WORDS must be a power of two in 2..256");
  end
  if ((BASE_ADDR & 32'(NUM_WORDS * 4 - 1)) != 0) begin : g_bad_base
    $error("BASE_ADDR must be aligned to the window size");
  end
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("WAIT_CYCLES must be in 1..15");
  end

  // Where each data phase starts once the previous one is done.
`ifdef TARGET_WAIT_EN
  localparam state_e PHASE_ST = ST_WAIT;
`else
  localparam state_e PHASE_ST = ST_XFER;
`endif

  state_e        state_q, state_d;
  logic          frame_prev_q;
  logic          is_rd_q, is_rd_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   ad_out_q, ad_out_d;
  logic          addr_phase;
  logic          in_range;
  logic          hit;
  logic          xfer;
  logic          rf_we;
  logic [31:0]   rf_rdata;
`ifdef TARGET_WAIT_EN
  logic [3:0]    wcnt_q, wcnt_d;
`endif

  assign in_range = (AD_IN[31:2] >= BASE_W) &&
                    (AD_IN[31:2] <  END_W);
  assign hit      = in_range && cmd_supported(CBE);

  // Address phase: falling FRAME seen from IDLE with IRDY high.
  assign addr_phase = (state_q == ST_IDLE) && !FRAME &&
                      frame_prev_q && IRDY;

  // TRDY is low exactly in XFER, so a transfer is XFER + IRDY low.
  assign xfer = (state_q == ST_XFER) && !IRDY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (addr_phase) begin
          if (!hit) begin
            state_d = ST_SKIP;
          end else if (CBE == CMD_MEM_RD) begin
            state_d = ST_RD_TA;
          end else begin
            state_d = PHASE_ST;
          end
        end
      end
      ST_SKIP: begin
        if (FRAME && IRDY) begin
          state_d = ST_IDLE;
        end
      end
      // The turnaround doubles as the first read phase's wait.
      ST_RD_TA: state_d = ST_XFER;
      ST_XFER: begin
        if (!IRDY) begin
          state_d = FRAME ? ST_TURN : PHASE_ST;
        end
      end
`ifdef TARGET_WAIT_EN
      ST_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = ST_XFER;
        end
      end
`endif
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    DEVSEL = 1'b1;
    TRDY   = 1'b1;
    AD_OE  = 1'b0;
    unique case (state_q)
      ST_RD_TA: DEVSEL = 1'b0;
      ST_XFER: begin
        DEVSEL = 1'b0;
        TRDY   = 1'b0;
        AD_OE  = is_rd_q;
      end
      ST_WAIT: begin
        DEVSEL = 1'b0;
        AD_OE  = is_rd_q;
      end
      default: begin
        DEVSEL = 1'b1;
      end
    endcase
  end

  assign AD_OUT = ad_out_q;

  always_comb begin
    is_rd_d = is_rd_q;
    idx_d   = idx_q;
    if (addr_phase && hit) begin
      is_rd_d = (CBE == CMD_MEM_RD);
      idx_d   = AD_IN[IW+1:2];
    end else if (xfer) begin
      idx_d = idx_q + IW'(1);
    end
  end

  // Read data follows the next index, so AD_OUT already holds
  // the word for the coming phase when TRDY goes low.
  always_comb begin
    ad_out_d = ad_out_q;
    if (is_rd_d &&
        (state_d inside {ST_RD_TA, ST_XFER, ST_WAIT})) begin
      ad_out_d = rf_rdata;
    end
  end

  assign rf_we = xfer && !is_rd_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_prev_q <= 1'b1;
      is_rd_q      <= 1'b0;
      idx_q        <= '0;
      ad_out_q     <= '0;
    end else begin
      frame_prev_q <= FRAME;
      is_rd_q      <= is_rd_d;
      idx_q        <= idx_d;
      ad_out_q     <= ad_out_d;
    end
  end

`ifdef TARGET_WAIT_EN
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_d == ST_WAIT && state_q != ST_WAIT) begin
      wcnt_d = 4'(WAIT_CYCLES - 1);
    end else if (state_q == ST_WAIT && wcnt_q != 4'd0) begin
      wcnt_d = wcnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt_q <= '0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end
`endif

  pci_target_regfile #(
    .NUM_WORDS(NUM_WORDS)
  ) u_regfile (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (rf_we),
    .waddr_i(idx_q),
    .wdata_i(AD_IN),
    .raddr_i(idx_d),
    .rdata_o(rf_rdata)
  );

endmodule

// File: doc/pci_simple_target.md
# pci_simple_target

Single-function PCI-style target (responder) that answers memory read and memory write bursts issued by the bus initiators over the shared FRAME/IRDY bus. It claims transactions whose address falls inside a window of NUM_WORDS 32-bit registers, asserts DEVSEL/TRDY, and absorbs write data into, or sources read data from, an internal register file. It sits on the global bus alongside the arbiter and the multiplexed initiator signals, and is the end that completes their data phases.

## Interface
- BASE_ADDR, 32'h0000_1000, byte base of the claimed window; aligned to NUM_WORDS*4
- NUM_WORDS, 8, register count; power of two, 2..256
- WAIT_CYCLES, 1, TRDY wait states per data phase (used only under TARGET_WAIT_EN); 1..15
- clk  input  1  bus clock; all activity on the rising edge
- rst  input  1  asynchronous, active-high reset
- FRAME  input  1  global FRAME, active-low
- IRDY  input  1  global IRDY, active-low
- AD_IN  input  32  address/data from the initiator
- CBE  input  4  command during the address phase (byte enables ignored)
- AD_OUT  output  32  read data
- AD_OE  output  1  high while the target drives AD
- DEVSEL  output  1  device select, active-low
- TRDY  output  1  target ready, active-low

## Operation
- Commands: 4'b0110 memory read, 4'b0111 memory write; any other command is not claimed.
- Address phase: in IDLE, the rising edge with FRAME=0, previous-cycle FRAME=1 and IRDY=1. Latch AD_IN and CBE.
- Hit: AD_IN[31:2] in [BASE_ADDR>>2, (BASE_ADDR>>2)+NUM_WORDS) and command supported; index = AD_IN[log2(NUM_WORDS)+1:2].
- States: IDLE, SKIP, RD_TA, XFER, WAIT, TURN.
- IDLE -> XFER on a write hit; IDLE -> RD_TA on a read hit; IDLE -> SKIP on a miss or unsupported command.
- SKIP -> IDLE on the edge that samples FRAME=1 and IRDY=1. Outputs stay deasserted throughout.
- RD_TA: one turnaround cycle with DEVSEL=0, TRDY=1, AD_OE=0; then XFER with AD_OE=1 and AD_OUT=mem[index].
- Data transfer: the edge sampling IRDY=0 and TRDY=0.
  - Write: mem[index] <= AD_IN.
  - Read: AD_OUT advances to mem[index+1] after that edge.
  - index increments and wraps modulo NUM_WORDS.
- Last phase: a transfer with FRAME=1 goes to TURN. TURN drives DEVSEL=1, TRDY=1, AD_OE=0 for one cycle, then IDLE.
- IRDY=1 in XFER: hold TRDY, AD_OUT and index unchanged.
- Reset, including mid-burst: state IDLE; DEVSEL=1, TRDY=1, AD_OE=0, AD_OUT=0; all registers 0; index 0.

## Timing
- Outputs are registered; no combinational path from inputs to outputs.
- Address sampled at edge A:
  - Write: DEVSEL=0 and TRDY=0 after A; first transfer possible at A+1.
  - Read: DEVSEL=0 after A; AD_OE=1 and TRDY=0 after A+1; first transfer possible at A+2.
- Zero wait states: one word per clock while IRDY=0.
- After the final transfer at edge F: outputs deasserted after F; TURN spans F..F+1; IDLE after F+1.
- Back-to-back: a new address phase is recognised from IDLE at F+2 at the earliest.

## Configuration
- TARGET_WAIT_EN defined: each data phase enters WAIT with TRDY=1 for WAIT_CYCLES cycles (4-bit counter), then XFER with TRDY=0.
  - The read turnaround counts as the first phase's wait.
  - DEVSEL timing is unchanged.
- Undefined: WAIT state, counter and WAIT_CYCLES are compiled out; zero wait states.

## Structure
- Package pci_target_pkg:
  - command localparams CMD_MEM_RD=4'b0110, CMD_MEM_WR=4'b0111
  - state encoding (IDLE, SKIP, RD_TA, XFER, WAIT, TURN)
- Sub-module pci_target_regfile: NUM_WORDS x 32 storage.
  - one write port, one read port, asynchronous clear on rst
  - read data registered into AD_OUT by the parent

## Test plan
- Reset mid-write-burst (rst pulse while TRDY=0) -> DEVSEL=1, TRDY=1, AD_OE=0 asynchronously; a following read of 0x1000 returns 0.
- Write 0x1000 with data 0xA5A5_0001, 0xA5A5_0002, 0xA5A5_0003, IRDY low throughout -> DEVSEL/TRDY low one edge after address; three transfers on consecutive edges; mem[0..2] hold the data.
- Read 0x1004, 2 words, after the write above -> turnaround cycle with AD_OE=0; AD_OUT=0xA5A5_0002 then 0xA5A5_0003; TURN; IDLE.
- Write 0x101C, 2 words (0x11, 0x22) -> mem[7]=0x11, mem[0]=0x22 (index wrap).
- Read 0x2000, and a separate transaction with CBE=4'b0010 at 0x1000 -> DEVSEL and TRDY stay 1; state returns to IDLE after FRAME=1 and IRDY=1.
- TARGET_WAIT_EN, WAIT_CYCLES=2, 2-word write with IRDY released 1 cycle mid-burst -> TRDY high 2 cycles before each phase; no transfer while IRDY=1; mem updated only on IRDY=0 and TRDY=0 edges.
